// File: rtl/conv_mac_pipe_param.sv
// Pipelined multiply-accumulate for the Conv/Pool datapath.
// Configurable widths, latency and signedness; grouped sums with sticky overflow.
module conv_mac_pipe_param #(
    parameter int A_WIDTH   = 16,
    parameter int B_WIDTH   = 16,
    parameter int ACC_WIDTH = 40,
    parameter int NUM_STAGE = 4,
    parameter int SIGNED_A  = 0,
    parameter int SIGNED_B  = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ce,
    input  logic                         in_valid,
    input  logic [A_WIDTH-1:0]           din0,
    input  logic [B_WIDTH-1:0]           din1,
    input  logic                         in_first,
    input  logic                         in_last,
    output logic                         prod_valid,
    output logic [A_WIDTH+B_WIDTH-1:0]   prod,
    output logic                         acc_valid,
    output logic [ACC_WIDTH-1:0]         dout,
    output logic                         acc_ovf
);

    localparam int P_WIDTH  = A_WIDTH + B_WIDTH;
    localparam int DLY      = NUM_STAGE - 1;
    localparam bit P_SIGNED = (SIGNED_A != 0) || (SIGNED_B != 0);

    logic [A_WIDTH-1:0]        a_q;
    logic [B_WIDTH-1:0]        b_q;
    logic                      v_q;
    logic                      f_q;
    logic                      l_q;

    logic signed [A_WIDTH:0]   a_ext;
    logic signed [B_WIDTH:0]   b_ext;
    logic [P_WIDTH-1:0]        p_mul;

    logic [P_WIDTH-1:0]        p_d [DLY];
    logic [DLY-1:0]            v_d;
    logic [DLY-1:0]            f_d;
    logic [DLY-1:0]            l_d;

    logic                      pf;
    logic                      pl;
    logic [ACC_WIDTH-1:0]      acc_q;
    logic                      sticky_q;
    logic [ACC_WIDTH-1:0]      p_ext;
    logic [ACC_WIDTH:0]        sum_w;
    logic [ACC_WIDTH-1:0]      acc_nxt;
    logic                      add_ovf;

    // Tags are masked by in_valid so bubbles never open or close a group.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q <= '0;
            b_q <= '0;
            v_q <= 1'b0;
            f_q <= 1'b0;
            l_q <= 1'b0;
        end else if (ce) begin
            v_q <= in_valid;
            f_q <= in_valid & in_first;
            l_q <= in_valid & in_last;
            if (in_valid) begin
                a_q <= din0;
                b_q <= din1;
            end
        end
    end

    always_comb begin
        a_ext = {(SIGNED_A != 0) && a_q[A_WIDTH-1], a_q};
        b_ext = {(SIGNED_B != 0) && b_q[B_WIDTH-1], b_q};
        p_mul = P_WIDTH'(a_ext) * P_WIDTH'(b_ext);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DLY; i++) begin
                p_d[i] <= '0;
            end
            v_d <= '0;
            f_d <= '0;
            l_d <= '0;
        end else if (ce) begin
            p_d[0] <= p_mul;
            v_d[0] <= v_q;
            f_d[0] <= f_q;
            l_d[0] <= l_q;
            for (int i = 1; i < DLY; i++) begin
                p_d[i] <= p_d[i-1];
                v_d[i] <= v_d[i-1];
                f_d[i] <= f_d[i-1];
                l_d[i] <= l_d[i-1];
            end
        end
    end

    assign prod       = p_d[DLY-1];
    assign prod_valid = v_d[DLY-1];
    assign pf         = f_d[DLY-1];
    assign pl         = l_d[DLY-1];

    always_comb begin
        p_ext = ACC_WIDTH'(prod);
        if (P_SIGNED) begin
            p_ext = ACC_WIDTH'($signed(prod));
        end
        sum_w   = {1'b0, acc_q} + {1'b0, p_ext};
        acc_nxt = pf ? p_ext : sum_w[ACC_WIDTH-1:0];
        add_ovf = 1'b0;
        if (!pf) begin
            if (P_SIGNED) begin
                add_ovf = (acc_q[ACC_WIDTH-1] == p_ext[ACC_WIDTH-1]) &&
                          (sum_w[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
            end else begin
                add_ovf = sum_w[ACC_WIDTH];
            end
        end
    end

    // A first sample restarts the sticky flag along with the sum.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q     <= '0;
            sticky_q  <= 1'b0;
            dout      <= '0;
            acc_valid <= 1'b0;
            acc_ovf   <= 1'b0;
        end else if (ce) begin
            acc_valid <= prod_valid & pl;
            if (prod_valid) begin
                acc_q    <= acc_nxt;
                sticky_q <= (sticky_q & ~pf) | add_ovf;
                if (pl) begin
                    dout    <= acc_nxt;
                    acc_ovf <= (sticky_q & ~pf) | add_ovf;
                end
            end
        end
    end

endmodule
